// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, stage and opcode encodings,
// the instruction-memory responder state type and an address range helper.
package cpu_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        IFetch    = 4'h0,
        Decode    = 4'h1,
        Execute   = 4'h2,
        Memory    = 4'h3,
        Writeback = 4'h4
    } cpu_stage_t;

    localparam logic [5:0] ADD = 6'h00;
    localparam logic [5:0] SUB = 6'h01;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_t;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a,
                                     input int unsigned depth);
        return {{(32-ADDR_W){1'b0}}, a} < depth;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / instruction response channel between CPU and imem.
// master = CPU fetch stage, slave = imem_responder.
interface imem_responder_if;
    import cpu_pkg::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              resp_ready;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage, one sync write and one sync read port.
// Ports: clk, i_we/i_waddr/i_wdata write, i_re/i_raddr read, o_rdata.
module imem_array
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read and write share one edge; the read samples the old word.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr[AW-1:0]];
        end
        if (i_we) begin
            r_mem[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, WAIT_STATES delay.
// Ports: clk, reset, bus (slave), load_en/load_addr/load_data, busy.
module imem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    imem_responder_if.slave   bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    imem_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_oor;
    logic [3:0]        r_wcnt;
    logic              r_cap;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic              r_busy;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_last_wait;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data;

    always_comb begin
        w_req_ready = (r_state == ST_IDLE) && !load_en;
        w_accept    = bus.req_valid && w_req_ready;
        w_last_wait = (r_state == ST_WAIT) && (r_wcnt <= 4'd1);
        w_rd_en     = 1'b0;
        w_rd_addr   = r_addr;
        // With no wait states the array is read on the acceptance edge.
        if (w_accept && (WAIT_STATES == 0)) begin
            w_rd_en   = addr_ok(bus.req_addr, DEPTH);
            w_rd_addr = bus.req_addr;
        end else if (w_last_wait) begin
            w_rd_en = !r_oor;
        end
        w_wr_en = load_en && addr_ok(load_addr, DEPTH);
    end

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // r_cap marks the cycle where the array output is registered
    // into the response; resp_valid rises on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_oor        <= 1'b0;
            r_wcnt       <= '0;
            r_cap        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr <= bus.req_addr;
                        r_oor  <= !addr_ok(bus.req_addr, DEPTH);
                        r_wcnt <= WS_INIT;
                        r_busy <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_RESP;
                            r_cap   <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_wcnt <= r_wcnt - 4'd1;
                    if (w_last_wait) begin
                        r_wcnt  <= '0;
                        r_state <= ST_RESP;
                        r_cap   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (r_cap) begin
                        r_cap        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_oor ? '0 : w_rd_data;
                        r_resp_err   <= r_oor;
                    end else if (r_resp_valid && bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cap        <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign busy           = r_busy;

endmodule
